// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM state encoding, default timing constants
// and the parity helper used by the host transmit and receive paths.
package ps2_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  // 100 us line inhibit and inter-event timeout at a 50 MHz system clock
  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 50000;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  function automatic logic odd_parity(input logic [DATA_W-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus falling-edge
// detect on the synchronized clock; both lines share the same latency.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2clk,
  input  logic ps2data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_p0, clk_p1, clk_p2;
  logic data_p0, data_p1;

  // Idle PS/2 lines float high, so every stage clears to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      clk_p2  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      clk_p0  <= ps2clk;
      clk_p1  <= clk_p0;
      clk_p2  <= clk_p1;
      data_p0 <= ps2data;
      data_p1 <= data_p0;
    end
  end

  assign clk_sync  = clk_p1;
  assign data_sync = data_p1;
  assign clk_fall  = clk_p2 & ~clk_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out data, parity and stop on device clock falls, then checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              ps2clk,
  input  logic              ps2data,
  output logic              ps2clk_oe,
  output logic              ps2data_oe,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] INHIBIT_END = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT_CYCLES);

  ps2_state_t        state;
  logic [CNT_W-1:0]  inh_cnt;
  logic [CNT_W-1:0]  to_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic              parity_q;

  logic clk_sync, data_sync, clk_fall;
  logic accept;
  logic cnt_run;
  logic tmo_watch;
  logic timeout;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .ps2clk   (ps2clk),
    .ps2data  (ps2data),
    .clk_sync (clk_sync),
    .data_sync(data_sync),
    .clk_fall (clk_fall)
  );

  // tx_ready is registered and only high in IDLE, so this also gates on state
  assign accept    = tx_valid & tx_ready;
  assign cnt_run   = state inside {RTS, DATA, PARITY, STOP, ACK, WAIT_IDLE};
  assign tmo_watch = state inside {DATA, PARITY, STOP, ACK, WAIT_IDLE};
  assign timeout   = tmo_watch && (to_cnt == TIMEOUT_END);

  // Byte and parity are captured once per transfer and only shift while in DATA
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q  <= tx_data;
      parity_q <= odd_parity(tx_data);
    end else if (state == DATA && clk_fall) begin
      shift_q  <= shift_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      tx_ready   <= 1'b0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (timeout) begin
        err        <= 1'b1;
        state      <= IDLE;
        ps2clk_oe  <= 1'b0;
        ps2data_oe <= 1'b0;
        busy       <= 1'b0;
        tx_ready   <= 1'b1;
      end else begin
        if (cnt_run) begin
          to_cnt <= clk_fall ? '0 : to_cnt + CNT_ONE;
        end

        case (state)
          IDLE: begin
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            if (accept) begin
              state     <= INHIBIT;
              tx_ready  <= 1'b0;
              busy      <= 1'b1;
              ps2clk_oe <= 1'b1;
            end
          end

          INHIBIT: begin
            if (inh_cnt == INHIBIT_END) begin
              state      <= RTS;
              ps2data_oe <= 1'b1;
              to_cnt     <= '0;
            end else begin
              inh_cnt <= inh_cnt + CNT_ONE;
            end
          end

          RTS: begin
            state     <= DATA;
            ps2clk_oe <= 1'b0;
          end

          DATA: begin
            if (clk_fall) begin
              ps2data_oe <= ~shift_q[0];
              bit_cnt    <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= PARITY;
              end
            end
          end

          PARITY: begin
            if (clk_fall) begin
              ps2data_oe <= ~parity_q;
              state      <= STOP;
            end
          end

          STOP: begin
            if (clk_fall) begin
              ps2data_oe <= 1'b0;
              state      <= ACK;
            end
          end

          ACK: begin
            if (clk_fall) begin
              if (!data_sync) begin
                state <= WAIT_IDLE;
              end else begin
                err      <= 1'b1;
                state    <= IDLE;
                busy     <= 1'b0;
                tx_ready <= 1'b1;
              end
            end
          end

          WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
              done     <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
            end
          end

          default: begin
            state      <= IDLE;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a clocking device model.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TMO = 500;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2clk_oe, ps2data_oe, busy, done, err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2clk, ps2data;

  assign ps2clk  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data = ~(ps2data_oe | dev_data_low);

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    chk_b("ready_before_send", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release();
    int n;
    n = 0;
    while (ps2clk_oe !== 1'b0 && n < INH + 40) begin
      @(negedge clk);
      n++;
    end
    chk_b("clk_release", ps2clk_oe, 1'b0);
  endtask

  task automatic clock_pulse();
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
  endtask

  task automatic dev_xfer(input logic ack_en, output logic [10:0] frame, output logic par_oe);
    frame  = '0;
    par_oe = 1'b0;
    frame[0] = ps2data;
    for (int i = 1; i <= 10; i++) begin
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      frame[i] = ps2data;
      if (i == 9) par_oe = ps2data_oe;
      dev_clk_low = 1'b0;
    end
    repeat (H / 2) @(negedge clk);
    dev_data_low = ack_en;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (H) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk_b("done_seen", done, 1'b1);
    @(negedge clk);
    chk_b("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    logic [10:0] frame;
    logic        par_oe;
    int          n, d0, e0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_b("rst_clk_oe", ps2clk_oe, 1'b0);
    chk_b("rst_data_oe", ps2data_oe, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_err", err, 1'b0);
    chk_b("rst_tx_ready", tx_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_b("ready_after_rst", tx_ready, 1'b1);
    chk_b("idle_busy", busy, 1'b0);

    // 0xED with ACK: inhibit length, RTS, frame seen by the device
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    chk_b("inh_busy", busy, 1'b1);
    chk_b("inh_not_ready", tx_ready, 1'b0);
    n = 0;
    while (ps2clk_oe === 1'b1 && ps2data_oe === 1'b0 && n < INH + 10) begin
      n++;
      @(negedge clk);
    end
    chk_i("inhibit_len", n, INH);
    chk_b("rts_clk_oe", ps2clk_oe, 1'b1);
    chk_b("rts_data_oe", ps2data_oe, 1'b1);
    @(negedge clk);
    chk_b("rts_clk_released", ps2clk_oe, 1'b0);
    dev_xfer(1'b1, frame, par_oe);
    chk_i("frame_ed", int'(frame), int'({1'b1, 1'b1, 8'hED, 1'b0}));
    wait_done();
    repeat (3) @(negedge clk);
    chk_i("ed_done_count", done_cnt - d0, 1);
    chk_i("ed_err_count", err_cnt - e0, 0);
    chk_b("ed_ready", tx_ready, 1'b1);

    // 0x01: parity bit 0 so the data line is driven low during PARITY
    d0 = done_cnt;
    send(8'h01);
    wait_release();
    dev_xfer(1'b1, frame, par_oe);
    chk_i("frame_01", int'(frame), int'({1'b1, 1'b0, 8'h01, 1'b0}));
    chk_b("parity_oe_01", par_oe, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    chk_i("01_done_count", done_cnt - d0, 1);

    // Missing ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF);
    wait_release();
    dev_xfer(1'b0, frame, par_oe);
    chk_i("frame_ff", int'(frame), int'({1'b1, 1'b1, 8'hFF, 1'b0}));
    repeat (5) @(negedge clk);
    chk_i("nack_err_count", err_cnt - e0, 1);
    chk_i("nack_done_count", done_cnt - d0, 0);
    chk_b("nack_ready", tx_ready, 1'b1);
    chk_b("nack_busy", busy, 1'b0);

    // Device never clocks after RTS
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5);
    wait_release();
    n = 0;
    while (err !== 1'b1 && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    chk_b("tmo_err_seen", err, 1'b1);
    chk_i("tmo_latency", n, TMO);
    chk_b("tmo_clk_oe", ps2clk_oe, 1'b0);
    chk_b("tmo_data_oe", ps2data_oe, 1'b0);
    @(negedge clk);
    chk_b("tmo_err_one_cycle", err, 1'b0);
    chk_b("tmo_ready", tx_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk_i("tmo_err_count", err_cnt - e0, 1);
    chk_i("tmo_done_count", done_cnt - d0, 0);

    // Reset during the 4th data bit of 0x33 (bit3 = 0 -> data line driven)
    send(8'h33);
    wait_release();
    repeat (3) clock_pulse();
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (6) @(negedge clk);
    chk_b("bit3_driven", ps2data_oe, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_b("async_rst_clk_oe", ps2clk_oe, 1'b0);
    chk_b("async_rst_data_oe", ps2data_oe, 1'b0);
    chk_b("async_rst_busy", busy, 1'b0);
    dev_clk_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_b("post_rst_ready", tx_ready, 1'b1);
    repeat (200) @(negedge clk);
    chk_i("post_rst_done", done_cnt - d0, 0);
    chk_i("post_rst_err", err_cnt - e0, 0);

    // tx_valid with 0x55 mid-transfer of 0xF4 must be ignored
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    repeat (10) @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_release();
    dev_xfer(1'b1, frame, par_oe);
    chk_i("frame_f4", int'(frame), int'({1'b1, 1'b0, 8'hF4, 1'b0}));
    wait_done();
    repeat (20) @(negedge clk);
    chk_i("f4_done_count", done_cnt - d0, 1);
    chk_i("f4_err_count", err_cnt - e0, 0);
    chk_b("f4_no_new_xfer", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter: INHIBIT_CYCLES, default 5000, clk cycles the PS/2 clock line is held low before a transfer (100 us at 50 MHz).
REQ-002 Parameter: TIMEOUT_CYCLES, default 50000, maximum clk cycles allowed between device events before the transfer is aborted.
REQ-003 clk  in  1  single system clock; all logic is clocked on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 tx_valid  in  1  request to send tx_data to the device.
REQ-006 tx_data  in  8  command or data byte to transmit.
REQ-007 tx_ready  out  1  high only in IDLE; the block accepts a byte on a cycle where tx_valid and tx_ready are both high.
REQ-008 ps2clk  in  1  raw PS/2 clock line, asynchronous.
REQ-009 ps2data  in  1  raw PS/2 data line, asynchronous.
REQ-010 ps2clk_oe  out  1  1 drives the PS/2 clock line low; 0 releases it (open-drain).
REQ-011 ps2data_oe  out  1  1 drives the PS/2 data line low; 0 releases it (open-drain).
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse when the device acknowledges the byte.
REQ-014 err  out  1  one-cycle pulse on missing ACK or timeout.

Function
REQ-015 ps2clk and ps2data SHALL each pass through a 2-flop synchronizer; a falling edge is the synchronized clock moving from 1 to 0 between consecutive cycles.
REQ-016 On acceptance, the block SHALL latch tx_data, compute odd parity (parity bit = ~^tx_data) and enter INHIBIT.
REQ-017 INHIBIT: ps2clk_oe=1, ps2data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-018 RTS: ps2data_oe=1 (start bit 0) for one cycle with ps2clk_oe still 1; then ps2clk_oe=0 and go to DATA.
REQ-019 DATA: on each detected falling edge, the next bit SHALL be presented LSB first as ps2data_oe = ~bit; after the 8th bit go to PARITY.
REQ-020 PARITY: on the next falling edge, present the parity bit as ps2data_oe = ~parity; go to STOP.
REQ-021 STOP: on the next falling edge, set ps2data_oe=0 (stop bit 1); go to ACK.
REQ-022 ACK: on the next falling edge, sample synchronized ps2data; if 0, go to WAIT_IDLE; if 1, pulse err and go to IDLE.
REQ-023 WAIT_IDLE: when synchronized ps2clk and ps2data are both 1, pulse done and go to IDLE.
REQ-024 A 16-bit cycle counter SHALL clear on entry to RTS and on every detected falling edge; reaching TIMEOUT_CYCLES in DATA, PARITY, STOP, ACK or WAIT_IDLE SHALL pulse err, release both lines and return to IDLE.
REQ-025 tx_valid while busy SHALL be ignored; the latched byte SHALL not change mid-transfer.
REQ-026 done and err SHALL never both be high in the same cycle; each is high for exactly one cycle per transfer.
REQ-027 In IDLE, ps2clk_oe=0 and ps2data_oe=0.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-029 While rst is high: state IDLE, ps2clk_oe=0, ps2data_oe=0, busy=0, done=0, err=0, tx_ready=0; counters and synchronizer flops SHALL be cleared, with synchronizers cleared to 1.
REQ-030 Reset asserted mid-transfer SHALL release both lines asynchronously, without waiting for a clk edge; no done or err pulse SHALL follow reset.
REQ-031 tx_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-032 A shared ps2 package SHALL hold the state encoding (IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAIT_IDLE) and the default INHIBIT_CYCLES and TIMEOUT_CYCLES constants for use by the PS/2 receive path.
REQ-033 One sub-module, ps2_line_sync, SHALL provide the 2-flop synchronizer and falling-edge detect, reusable by the receiver.

Verification
REQ-034 tx_data=0xED, device model clocks at 12 kHz and ACKs -> ps2clk_oe high for 5000 cycles; the device sees start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; err stays 0.
REQ-035 tx_data=0x01 -> parity bit 0, so ps2data_oe=1 during PARITY; done pulses.
REQ-036 Device leaves data high at the ACK edge -> err pulses once, done stays 0, tx_ready returns high.
REQ-037 Device never clocks after RTS -> err pulses 50000 cycles after the clock is released; both oe outputs are 0.
REQ-038 rst asserted during the 4th data bit -> ps2clk_oe and ps2data_oe both 0 before the next clk edge; after release, tx_ready=1 and no done or err pulse occurs.
REQ-039 tx_valid pulsed with 0x55 during the transfer of 0xF4 -> the device receives only 0xF4; exactly one done pulse.
